// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the two-port memory arbiter.
//   arb_state_t   : arbiter FSM states
//   arb_port_t    : which CPU port owns the current transaction
//   ARB_TIMEOUT_W : width of the pmem_resp watchdog counter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } arb_port_t;

   localparam int ARB_TIMEOUT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the instruction port, the data port, the physical-memory initiator
// port and the sticky error flag of the arbiter.
//   slave  : arbiter view (CPU requests and pmem_rdata/pmem_resp in,
//            responses and pmem strobes out)
//   master : environment view (CPU + memory model), directions reversed
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] i_addr;
   logic              i_read;
   logic [DATA_W-1:0] i_rdata;
   logic              i_resp;

   logic [ADDR_W-1:0] d_addr;
   logic              d_read;
   logic              d_write;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_resp;

   logic [ADDR_W-1:0] pmem_addr;
   logic              pmem_read;
   logic              pmem_write;
   logic [DATA_W-1:0] pmem_wdata;
   logic [DATA_W-1:0] pmem_rdata;
   logic              pmem_resp;

   logic              err;

   modport slave (
      input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
             pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_addr, pmem_read, pmem_write, pmem_wdata, err
   );

   modport master (
      output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
             pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_addr, pmem_read, pmem_write, pmem_wdata, err
   );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// mem_port_arbiter_watchdog
// Counts busy cycles without a memory response and flags expiry.
//   clk, reset_n : clock, async active-low reset
//   clear        : zero the counter (held while the arbiter is idle)
//   enable       : busy cycle without pmem_resp
//   expire       : this enabled cycle is the LIMIT-th one; LIMIT=0 disables
module mem_port_arbiter_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [ARB_TIMEOUT_W-1:0] LAST = ARB_TIMEOUT_W'(LIMIT - 1);

   logic [ARB_TIMEOUT_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Expiry fires in the cycle that would take the count to LIMIT, so the
   // strobes are seen for exactly LIMIT busy cycles.
   assign expire = (LIMIT != 0) && enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serializes the CPU instruction-fetch port and data port onto one
// physical-memory initiator port, one transaction at a time, and returns a
// one-cycle resp pulse plus registered rdata to the requesting port.
//   clk, reset_n : clock, async active-low reset
//   bus          : mem_port_arbiter_if.slave (i_*, d_*, pmem_*, err)
// Build option: define ARB_FAIRNESS_EN to alternate grants when both ports
// are pending; otherwise the data port has strict priority.
//
// state  | meaning
// IDLE   | sample requests, capture the granted port's addr/wdata/op
// I_BUSY | instruction read on pmem, waiting for pmem_resp
// D_BUSY | data read/write on pmem, waiting for pmem_resp
// RESP   | resp pulse to the granted port, requests ignored
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_port_arbiter_if.slave  bus
);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_I_BUSY = I_BUSY;
   localparam logic [1:0] S_D_BUSY = D_BUSY;
   localparam logic [1:0] S_RESP   = RESP;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   arb_port_t         port_q;
   logic              op_write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              err_q;

   logic              busy;
   logic              expire;
   logic              done;
   logic              d_req;
   logic              grant_d;
   logic              grant_i;
   logic [DATA_W-1:0] done_data;

   assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_FAIRNESS_EN
   logic last_was_d;
   assign grant_d = d_req && !(last_was_d && bus.i_read);
`else
   assign grant_d = d_req;
`endif
   assign grant_i = bus.i_read && !grant_d;

   assign busy = (state == S_I_BUSY) || (state == S_D_BUSY);
   assign done = busy && (bus.pmem_resp || expire);
   // A timed-out transaction returns zero data.
   assign done_data = bus.pmem_resp ? bus.pmem_rdata : '0;

   mem_port_arbiter_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state == S_IDLE),
      .enable  (busy && !bus.pmem_resp),
      .expire  (expire)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (grant_d) begin
               state_nxt = S_D_BUSY;
            end else if (grant_i) begin
               state_nxt = S_I_BUSY;
            end
         end
         S_I_BUSY, S_D_BUSY: begin
            if (done) begin
               state_nxt = S_RESP;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         port_q     <= PORT_I;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && (grant_d || grant_i)) begin
            port_q     <= grant_d ? PORT_D : PORT_I;
            // read+write together is resolved as a write and flagged
            op_write_q <= grant_d && bus.d_write;
            addr_q     <= grant_d ? bus.d_addr : bus.i_addr;
            wdata_q    <= bus.d_wdata;
            if (grant_d && bus.d_read && bus.d_write) begin
               err_q <= 1'b1;
            end
         end
         if (done) begin
            if (port_q == PORT_I) begin
               i_rdata_q <= done_data;
            end else if (!op_write_q || expire) begin
               d_rdata_q <= done_data;
            end
            if (expire) begin
               err_q <= 1'b1;
            end
         end
      end
   end

`ifdef ARB_FAIRNESS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_was_d <= 1'b0;
      end else if (state == S_IDLE && (grant_d || grant_i)) begin
         last_was_d <= grant_d;
      end
   end
`endif

   assign bus.pmem_read  = busy && !op_write_q;
   assign bus.pmem_write = busy && op_write_q;
   assign bus.pmem_addr  = busy ? addr_q : '0;
   assign bus.pmem_wdata = (busy && op_write_q) ? wdata_q : '0;

   assign bus.i_resp  = (state == S_RESP) && (port_q == PORT_I);
   assign bus.d_resp  = (state == S_RESP) && (port_q == PORT_D);
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed and random transactions against mem_port_arbiter (TIMEOUT=4),
// checked against a transaction-level model of grant order, pmem strobes,
// response timing, rdata and the sticky error flag.
module tb_mem_port_arbiter;

   localparam int TO = 4;
`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   int   n_asserts = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_port_arbiter #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .TIMEOUT (TO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Pending requests as the CPU sees them.
   logic        i_pend, d_pend, drd, dwr;
   logic [15:0] ia, da, dwd;
   // Model state.
   logic        last_d;
   logic [15:0] exp_i_rdata, exp_d_rdata;
   logic        exp_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_inputs();
      bus.i_read  = i_pend;
      bus.i_addr  = ia;
      bus.d_read  = d_pend && drd;
      bus.d_write = d_pend && dwr;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
   endtask

   task automatic model_reset();
      last_d      = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      exp_err     = 1'b0;
   endtask

   // Runs one transaction from an IDLE cycle: lat = wait cycles before
   // pmem_resp, lat < 0 means memory never answers.
   task automatic serve(input int lat, input logic [15:0] mem_data,
                        output int resp_cyc, output bit won_d);
      bit          wd, is_wr;
      int          nb;
      logic [15:0] exp_addr;
      wd       = d_pend && !(FAIR && last_d && i_pend);
      is_wr    = wd && dwr;
      exp_addr = wd ? da : ia;
      if (wd && drd && dwr) exp_err = 1'b1;
      apply_inputs();
      nb = (lat < 0) ? TO : lat + 1;
      for (int k = 1; k <= nb; k++) begin
         @(posedge clk); #1;
         check("busy_pmem_read", bus.pmem_read, !is_wr);
         check("busy_pmem_write", bus.pmem_write, is_wr);
         check("busy_pmem_addr", bus.pmem_addr, exp_addr);
         if (is_wr) check("busy_pmem_wdata", bus.pmem_wdata, dwd);
         check("busy_no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
         if (lat >= 0 && k == nb) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = mem_data;
         end
      end
      @(posedge clk); #1;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = 16'($urandom);
      if (lat < 0) begin
         exp_err = 1'b1;
         if (wd) exp_d_rdata = '0; else exp_i_rdata = '0;
      end else if (!is_wr) begin
         if (wd) exp_d_rdata = mem_data; else exp_i_rdata = mem_data;
      end
      resp_cyc = cyc;
      check("resp_i", bus.i_resp, !wd);
      check("resp_d", bus.d_resp, wd);
      check("resp_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
      check("i_rdata", bus.i_rdata, exp_i_rdata);
      check("d_rdata", bus.d_rdata, exp_d_rdata);
      check("err", bus.err, exp_err);
      last_d = wd;
      won_d  = wd;
      if (wd) d_pend = 1'b0; else i_pend = 1'b0;
      apply_inputs();
      @(posedge clk); #1;
      check("idle_no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
      check("idle_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit observed=expired required=finish");
      $fatal(1);
   end

   initial begin
      int  rc1, rc2, op;
      bit  wd1, wd2;
      reset_n = 1'b0;
      i_pend = 0; d_pend = 0; drd = 0; dwr = 0;
      ia = '0; da = '0; dwd = '0;
      bus.pmem_resp = 1'b0;
      bus.pmem_rdata = '0;
      apply_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs",
            {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.err}, 5'b0);
      check("rst_pmem_addr", bus.pmem_addr, 16'h0);
      check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 32'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Single instruction read, two wait cycles.
      i_pend = 1; ia = 16'h0040;
      serve(2, 16'h1234, rc1, wd1);
      repeat (2) @(posedge clk);
      #1;
      check("i_rdata_hold", bus.i_rdata, 16'h1234);

      // Data write.
      d_pend = 1; drd = 0; dwr = 1; da = 16'h0100; dwd = 16'hBEEF;
      serve(1, 16'hAAAA, rc1, wd1);

      // Both ports at once, zero-wait memory.
      i_pend = 1; ia = 16'h0300;
      d_pend = 1; drd = 1; dwr = 0; da = 16'h0400;
      serve(0, 16'h1111, rc1, wd1);
      serve(0, 16'h2222, rc2, wd2);
      check("back_to_back_gap", rc2 - rc1, 3);

      // D alone, then both pending: fairness decides who goes next.
      d_pend = 1; drd = 1; dwr = 0; da = 16'h0600;
      serve(0, 16'h3333, rc1, wd1);
      i_pend = 1; ia = 16'h0700;
      d_pend = 1; drd = 1; dwr = 0; da = 16'h0800;
      serve(1, 16'h4444, rc1, wd1);
      check("fair_winner_is_d", wd1, !FAIR);
      serve(0, 16'h5555, rc2, wd2);

      // Read and write together resolves as a write and flags err.
      d_pend = 1; drd = 1; dwr = 1; da = 16'h0500; dwd = 16'h0F0F;
      serve(0, 16'h6666, rc1, wd1);

      // Reset in the middle of a data write, then a stray pmem_resp.
      d_pend = 1; drd = 0; dwr = 1; da = 16'h0200; dwd = 16'h5555;
      apply_inputs();
      @(posedge clk); #1;
      check("pre_rst_write", bus.pmem_write, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_outputs",
            {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.err}, 5'b0);
      check("mid_rst_pmem", {bus.pmem_addr, bus.pmem_wdata}, 32'h0);
      check("mid_rst_rdata", {bus.i_rdata, bus.d_rdata}, 32'h0);
      model_reset();
      d_pend = 0;
      apply_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      bus.pmem_resp = 1'b1;
      bus.pmem_rdata = 16'hDEAD;
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      check("late_resp_ignored",
            {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write, bus.err}, 5'b0);
      check("late_resp_rdata", bus.d_rdata, 16'h0);
      @(posedge clk); #1;
      check("late_resp_quiet", {bus.i_resp, bus.d_resp}, 2'b00);

      // Memory never answers.
      i_pend = 1; ia = 16'h0ABC;
      serve(-1, 16'h0, rc1, wd1);

      // Random traffic.
      for (int n = 0; n < 30; n++) begin
         if (!i_pend && $urandom_range(0, 1) == 1) begin
            i_pend = 1; ia = 16'($urandom);
         end
         if (!d_pend && $urandom_range(0, 2) != 0) begin
            d_pend = 1;
            op  = $urandom_range(0, 9);
            drd = (op < 5) || (op == 9);
            dwr = (op >= 5);
            da  = 16'($urandom);
            dwd = 16'($urandom);
         end
         if (!i_pend && !d_pend) begin
            i_pend = 1; ia = 16'($urandom);
         end
         serve($urandom_range(0, 3), 16'($urandom), rc1, wd1);
      end
      if (i_pend || d_pend) serve(0, 16'h7777, rc1, wd1);
      if (i_pend || d_pend) serve(0, 16'h8888, rc1, wd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
